// File: rtl/addr_reg_slave_if.sv
// Avalon-MM slave port bundle for the address-master register bank.
// The master drives the command and the slave returns data and stall.
interface addr_reg_slave_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) ();
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              read;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, write, writedata, read,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/addr_reg_slave.sv
// Eight-byte Avalon-MM register bank with fixed wait states, sticky update flags
// and a saturating committed-write counter exported as conduits.

module addr_reg_slice #(
    parameter int                 DATA_W      = 8,
    parameter logic [DATA_W-1:0]  RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    output logic [DATA_W-1:0] q,
    output logic              upd
);
    // A commit sets the flag even when a clear arrives on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q   <= RESET_VALUE;
            upd <= 1'b0;
        end else begin
            if (we)
                q <= wdata;
            if (we)
                upd <= 1'b1;
            else if (clr)
                upd <= 1'b0;
        end
    end
endmodule

module addr_reg_slave #(
    parameter int                ADDR_W      = 3,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] RESET_VALUE = 8'h00,
    localparam int               NUM_REGS    = 2 ** ADDR_W
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    addr_reg_slave_if.slave              avs,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out_conduit,
    output logic [NUM_REGS-1:0]          updated_conduit,
    input  logic                         clear_flags_conduit,
    output logic [15:0]                  write_count_conduit
);
    typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT, RD_ACK} state_t;

    state_t                           state_q, state_d;
    logic   [ADDR_W-1:0]              addr_q;
    logic   [DATA_W-1:0]              wdata_q;
    logic   [DATA_W-1:0]              rdata_q;
    logic                             rdv_q, rdv_d;
    logic                             wait_q, wait_d;
    logic   [15:0]                    cnt_q;
    logic                             latch_wr, latch_rd, load_rd, commit, rd_clr;
    logic   [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic   [NUM_REGS-1:0]            upd;

    always_comb begin
        state_d  = state_q;
        latch_wr = 1'b0;
        latch_rd = 1'b0;
        load_rd  = 1'b0;
        commit   = 1'b0;
        rd_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (avs.write) begin
                    state_d  = WR_ACK;
                    latch_wr = 1'b1;
                end else if (avs.read) begin
                    state_d  = RD_WAIT;
                    latch_rd = 1'b1;
                end
            end
            WR_ACK: begin
                // A write withdrawn during the ack cycle is aborted silently.
                commit  = avs.write;
                state_d = IDLE;
            end
            RD_WAIT: begin
                load_rd = 1'b1;
                state_d = RD_ACK;
            end
            RD_ACK: begin
                rd_clr  = rdv_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        wait_d = !((state_d == WR_ACK) || (state_d == RD_ACK));
        // Data is only reported if the master still holds read going into the ack.
        rdv_d  = (state_q == RD_WAIT) && avs.read;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rdv_q   <= 1'b0;
            wait_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdv_q   <= rdv_d;
            wait_q  <= wait_d;
            if (latch_wr || latch_rd)
                addr_q <= avs.address;
            if (latch_wr)
                wdata_q <= avs.writedata;
            if (load_rd)
                rdata_q <= regs[addr_q];
            if (commit && (cnt_q != 16'hFFFF))
                cnt_q <= cnt_q + 16'd1;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic hit;
        assign hit = (addr_q == ADDR_W'(i));

        addr_reg_slice #(
            .DATA_W      (DATA_W),
            .RESET_VALUE (RESET_VALUE)
        ) u_slice (
            .clk   (clk_clk),
            .rst_n (reset_reset_n),
            .we    (commit && hit),
            .wdata (wdata_q),
            .clr   (clear_flags_conduit || (rd_clr && hit)),
            .q     (regs[i]),
            .upd   (upd[i])
        );
    end

    assign avs.readdata        = rdata_q;
    assign avs.readdatavalid   = rdv_q;
    assign avs.waitrequest     = wait_q;
    assign reg_out_conduit     = regs;
    assign updated_conduit     = upd;
    assign write_count_conduit = cnt_q;
endmodule

// File: tb/tb_addr_reg_slave.sv
// Directed bench for addr_reg_slave: reset, write/read, collisions, aborts,
// flag-clear race and counter saturation with hand-computed expectations.
module tb_addr_reg_slave;
    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [63:0] reg_out;
    logic [7:0]  updated;
    logic        clear_flags;
    logic [15:0] wcount;
    int          checks = 0;
    int          errors = 0;

    addr_reg_slave_if #(.ADDR_W(3), .DATA_W(8)) avs_if ();

    addr_reg_slave #(.ADDR_W(3), .DATA_W(8), .RESET_VALUE(8'h00)) dut (
        .clk_clk             (clk_clk),
        .reset_reset_n       (reset_reset_n),
        .avs                 (avs_if),
        .reg_out_conduit     (reg_out),
        .updated_conduit     (updated),
        .clear_flags_conduit (clear_flags),
        .write_count_conduit (wcount)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Full write: request in IDLE, held through the single ack cycle, then dropped.
    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        avs_if.write     = 1'b1;
        avs_if.address   = a;
        avs_if.writedata = d;
        tick();
        tick();
        avs_if.write = 1'b0;
    endtask

    initial begin
        reset_reset_n    = 1'b0;
        clear_flags      = 1'b0;
        avs_if.address   = '0;
        avs_if.write     = 1'b0;
        avs_if.writedata = '0;
        avs_if.read      = 1'b0;

        tick();
        tick();
        chk("rst_reg_out", reg_out, 64'h0);
        chk("rst_updated", {56'h0, updated}, 64'h0);
        chk("rst_count", {48'h0, wcount}, 64'h0);
        chk("rst_wait", {63'h0, avs_if.waitrequest}, 64'h1);
        chk("rst_rdv", {63'h0, avs_if.readdatavalid}, 64'h0);
        chk("rst_rdata", {56'h0, avs_if.readdata}, 64'h0);
        reset_reset_n = 1'b1;
        tick();
        chk("idle_wait", {63'h0, avs_if.waitrequest}, 64'h1);

        // write A5 -> reg3, cycle by cycle
        avs_if.write = 1'b1; avs_if.address = 3'd3; avs_if.writedata = 8'hA5;
        tick();
        chk("wr_ack_wait_low", {63'h0, avs_if.waitrequest}, 64'h0);
        chk("wr_not_yet", reg_out, 64'h0);
        tick();
        avs_if.write = 1'b0;
        chk("wr_wait_high_again", {63'h0, avs_if.waitrequest}, 64'h1);
        chk("wr_reg3", {56'h0, reg_out[31:24]}, 64'hA5);
        chk("wr_updated", {56'h0, updated}, 64'h08);
        chk("wr_count1", {48'h0, wcount}, 64'd1);

        // read reg3
        avs_if.read = 1'b1; avs_if.address = 3'd3;
        tick();
        chk("rd_wait_rdv0", {63'h0, avs_if.readdatavalid}, 64'h0);
        chk("rd_wait_wait1", {63'h0, avs_if.waitrequest}, 64'h1);
        tick();
        avs_if.read = 1'b0;
        chk("rd_ack_rdv1", {63'h0, avs_if.readdatavalid}, 64'h1);
        chk("rd_ack_wait0", {63'h0, avs_if.waitrequest}, 64'h0);
        chk("rd_data", {56'h0, avs_if.readdata}, 64'hA5);
        tick();
        chk("rd_pulse_end", {63'h0, avs_if.readdatavalid}, 64'h0);
        chk("rd_clears_flag", {56'h0, updated}, 64'h00);

        // read and write together: write wins
        avs_if.read = 1'b1; avs_if.write = 1'b1; avs_if.address = 3'd5; avs_if.writedata = 8'h3C;
        tick();
        chk("rw_wait0", {63'h0, avs_if.waitrequest}, 64'h0);
        chk("rw_rdv0_a", {63'h0, avs_if.readdatavalid}, 64'h0);
        tick();
        avs_if.read = 1'b0; avs_if.write = 1'b0;
        chk("rw_reg5", {56'h0, reg_out[47:40]}, 64'h3C);
        chk("rw_rdv0_b", {63'h0, avs_if.readdatavalid}, 64'h0);
        chk("rw_updated", {56'h0, updated}, 64'h20);
        chk("rw_count2", {48'h0, wcount}, 64'd2);
        tick();
        chk("rw_rdv0_c", {63'h0, avs_if.readdatavalid}, 64'h0);

        // write dropped during the ack cycle: aborted
        avs_if.write = 1'b1; avs_if.address = 3'd1; avs_if.writedata = 8'h77;
        tick();
        avs_if.write = 1'b0;
        tick();
        chk("abort_reg1", {56'h0, reg_out[15:8]}, 64'h00);
        chk("abort_count", {48'h0, wcount}, 64'd2);
        chk("abort_updated", {56'h0, updated}, 64'h20);

        // set every flag, then commit to reg0 while clearing
        for (int i = 0; i < 8; i++) do_write(3'(i), 8'h10 + 8'(i));
        chk("all_flags", {56'h0, updated}, 64'hFF);
        chk("count10", {48'h0, wcount}, 64'd10);
        avs_if.write = 1'b1; avs_if.address = 3'd0; avs_if.writedata = 8'hC3;
        tick();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0; avs_if.write = 1'b0;
        chk("race_updated", {56'h0, updated}, 64'h01);
        chk("race_regs", reg_out, 64'h17161514_131211C3);
        chk("race_count", {48'h0, wcount}, 64'd11);

        // reset in the ack cycle of a write
        avs_if.write = 1'b1; avs_if.address = 3'd2; avs_if.writedata = 8'hEE;
        tick();
        chk("mid_wait0", {63'h0, avs_if.waitrequest}, 64'h0);
        reset_reset_n = 1'b0;
        tick();
        reset_reset_n = 1'b1; avs_if.write = 1'b0;
        chk("mid_rst_regs", reg_out, 64'h0);
        chk("mid_rst_count", {48'h0, wcount}, 64'd0);
        chk("mid_rst_updated", {56'h0, updated}, 64'h00);
        chk("mid_rst_wait", {63'h0, avs_if.waitrequest}, 64'h1);
        tick();
        chk("post_rst_reg2", {56'h0, reg_out[23:16]}, 64'h00);

        // saturation from FFFE
        force dut.cnt_q = 16'hFFFE;
        tick();
        release dut.cnt_q;
        chk("sat_preload", {48'h0, wcount}, 64'hFFFE);
        do_write(3'd6, 8'h61);
        chk("sat_first", {48'h0, wcount}, 64'hFFFF);
        do_write(3'd6, 8'h62);
        chk("sat_second", {48'h0, wcount}, 64'hFFFF);
        do_write(3'd7, 8'h71);
        chk("sat_third", {48'h0, wcount}, 64'hFFFF);
        chk("sat_regs", reg_out, 64'h71620000_00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
